decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Buffered, parametrised decode stage between fetch and dispatch in the tensor-core front end.
- Accepts raw instructions plus their PC over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Decodes the FIFO head into a packed decode_t bundle for dispatch, covering scalar, matrix load/store and GEMM.
- Adds behaviour the current single-cycle control decode lacks: backpressure, flush, halt fencing, illegal-instruction flagging and full GEMM source-register decode.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
WORD_W, 32, instruction, PC and immediate width
MREG_W, 4, matrix register index width
SREG_W, 5, scalar register index width

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
fetch_valid  in  1  fetch presents an instruction
fetch_ready  out  1  queue can accept
fetch_instr  in  WORD_W  raw instruction
fetch_pc  in  WORD_W  PC of fetch_instr
dec_valid  out  1  head entry is valid
dec_ready  in  1  dispatch consumes the head
dec_out  out  $bits(decode_t)  decoded head, including pc
flush  in  1  discard all queued entries
halted  out  1  a HALT has been issued to dispatch
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: RST is sampled on the CLK edge. It clears pointers, count, halt_in_q and halted. After reset, dec_valid=0, fetch_ready=1, count=0 and dec_out is all zeros.
- Push when fetch_valid && fetch_ready. Pop when dec_valid && dec_ready.
- fetch_ready = !full && !halt_in_q && !halted. There is no combinational path from dec_ready to fetch_ready; a pop frees a slot from the next cycle.
- Latency: an instruction pushed in cycle t is visible at the head in cycle t+1 at the earliest.
- dec_valid = (count != 0).
- dec_out is a combinational decode of the registered head entry and holds stable while dec_valid && !dec_ready.
- Simultaneous push and pop (count not full): count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Flush has priority over push and pop in the same cycle. It empties the FIFO next cycle and clears halt_in_q, but does not clear halted.
- Halt fence: pushing a HALT opcode sets halt_in_q, so no further fetches are accepted. Popping a HALT sets halted=1, which is sticky until RST.
- Decode rules, all fields defaulting to zero, fu_t=FU_S_T, fu_s=FU_NONE:
  - RTYPE: alu_op from funct3; funct7=0x20 selects SUB/SRA; s_reg_write=1; fu_s=FU_S_ALU.
  - ITYPE: same as RTYPE plus i_flag=1 and imm = sign-extended I-immediate.
  - LW (funct3=2): s_mem_type=LOAD, fu_s=FU_S_LD_ST, s_reg_write=1, i_flag=1, I-immediate.
  - SW (funct3=2): s_mem_type=STORE, fu_s=FU_S_LD_ST, i_flag=1, S-immediate.
  - BTYPE: branch_op from funct3, fu_s=FU_S_BRANCH, B-immediate with bit 0 = 0.
  - JAL: J-immediate, jal=1, s_reg_write=1, alu_op=ALU_ADD, i_flag=1, fu_s=FU_S_ALU.
  - JALR: I-immediate, jalr=1, s_reg_write=1, alu_op=ALU_ADD, i_flag=1, fu_s=FU_S_ALU.
  - LD_M / ST_M: imm = sign-extend(instr[17:7]), stride reg = instr[22:18], mrd = instr[31:28], fu_m=FU_M_LD_ST, fu_t=FU_M_T. m_mem_type is M_LOAD or M_STORE. LD_M also sets m_reg_write=1.
  - GEMM: mrd=[31:28], mrs1=[27:24], mrs2=[23:20], mrs3=[19:16]; fu_m=FU_M_GEMM, m_reg_write=1, fu_t=FU_G_T.
  - HALT: halt=1.
- Scalar rd=[11:7], rs1=[19:15] and rs2=[24:20] are extracted for all scalar formats.
- Illegal instruction: an unknown opcode, LW/SW with funct3 != 2, or an undefined branch funct3. It produces illegal=1 with no writes, fu_s=FU_NONE, and is still passed to dispatch.

Decomposition:
- isa_pkg (existing): opcode and funct3 enums; add the GEMM source-field positions.
- datapath_pkg: add decode_t (pc, alu_op, branch_op, imm, stride, rd, rs1, rs2, mrd, mrs1..3, fu_t, fu_s, fu_m, s_mem_type, m_mem_type, s_reg_write, m_reg_write, i_flag, jal, jalr, halt, illegal).
- Sub-module instr_decoder: purely combinational, instr in / decode_t out. The FIFO, fence and flush logic remain in decode_queue.

Test Plan:
- Push 0x00500093 (addi x1,x0,5) at cycle 0 with dec_ready=1 -> cycle 1: dec_valid=1, alu_op=ALU_ADD, imm=5, rd=1, i_flag=1, s_reg_write=1; cycle 2: count=0.
- Push 0xFE000EE3 (beq x0,x0,-4) -> branch_op=BT_BEQ, imm=0xFFFFFFFC, fu_s=FU_S_BRANCH, no writes.
- dec_ready=0, push 4 instructions -> count=4, fetch_ready=0. Then pop 1 and push 1 in the same cycle -> count stays 4. Verify FIFO order across pointer wrap.
- Push HALT, then hold fetch_valid=1 -> fetch_ready=0 next cycle. After the HALT pops -> halted=1. A subsequent flush leaves halted=1.
- 3 entries queued; assert flush together with a push -> next cycle count=0, dec_valid=0, and the pushed instruction is absent.
- Push a GEMM with mrd=2, mrs1=3, mrs2=4, mrs3=5 -> matching fields, fu_t=FU_G_T. Push opcode 0x7F -> illegal=1. Assert RST mid-stream -> count=0 and halted=0 next cycle.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared ISA encodings and the decoded-instruction bundle for the front-end decode queue.
package decode_queue_pkg;

    localparam int WORD_W = 32;
    localparam int MREG_W = 4;
    localparam int SREG_W = 5;

    // Matrix register fields of a GEMM word, given as lsb positions of MREG_W-wide fields
    localparam int GEMM_MRD_LSB  = 28;
    localparam int GEMM_MRS1_LSB = 24;
    localparam int GEMM_MRS2_LSB = 20;
    localparam int GEMM_MRS3_LSB = 16;

    typedef enum logic [6:0] {
        OP_LW    = 7'b0000011,
        OP_LD_M  = 7'b0001011,
        OP_ITYPE = 7'b0010011,
        OP_SW    = 7'b0100011,
        OP_ST_M  = 7'b0101011,
        OP_RTYPE = 7'b0110011,
        OP_GEMM  = 7'b1011011,
        OP_BTYPE = 7'b1100011,
        OP_JALR  = 7'b1100111,
        OP_JAL   = 7'b1101111,
        OP_HALT  = 7'b1111011
    } opcode_t;

    localparam logic [2:0] F3_WORD = 3'd2;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        BT_NONE, BT_BEQ, BT_BNE, BT_BLT, BT_BGE, BT_BLTU, BT_BGEU
    } branch_op_t;

    typedef enum logic [1:0] {FU_S_T, FU_M_T, FU_G_T} fu_t_t;
    typedef enum logic [1:0] {FU_NONE, FU_S_ALU, FU_S_LD_ST, FU_S_BRANCH} fu_s_t;
    typedef enum logic [1:0] {FU_M_NONE, FU_M_LD_ST, FU_M_GEMM} fu_m_t;
    typedef enum logic [1:0] {MEM_NONE, LOAD, STORE} s_mem_t;
    typedef enum logic [1:0] {M_NONE, M_LOAD, M_STORE} m_mem_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        alu_op_t           alu_op;
        branch_op_t        branch_op;
        logic [WORD_W-1:0] imm;
        logic [SREG_W-1:0] stride;
        logic [SREG_W-1:0] rd;
        logic [SREG_W-1:0] rs1;
        logic [SREG_W-1:0] rs2;
        logic [MREG_W-1:0] mrd;
        logic [MREG_W-1:0] mrs1;
        logic [MREG_W-1:0] mrs2;
        logic [MREG_W-1:0] mrs3;
        fu_t_t             fu_t;
        fu_s_t             fu_s;
        fu_m_t             fu_m;
        s_mem_t            s_mem_type;
        m_mem_t            m_mem_type;
        logic              s_reg_write;
        logic              m_reg_write;
        logic              i_flag;
        logic              jal;
        logic              jalr;
        logic              halt;
        logic              illegal;
    } decode_t;

endpackage

// File: rtl/decode_queue_instr_decoder.sv
// Combinational decode of one raw instruction word into a decode_t bundle.
module instr_decoder
    import decode_queue_pkg::*;
(
    input  logic [WORD_W-1:0] instr,
    input  logic [WORD_W-1:0] pc,
    output decode_t           dec
);

    function automatic logic [WORD_W-1:0] sext(input logic [WORD_W-1:0] v, input int unsigned bits);
        logic signed [WORD_W-1:0] t;
        t = signed'(v << (WORD_W - bits));
        return t >>> (WORD_W - bits);
    endfunction

    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        op = ALU_ADD;
        case (f3)
            3'd0: op = alt ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = alt ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [2:0] f3;
    logic       f7_alt;
    logic       scalar;
    logic       bad;

    assign f3     = instr[14:12];
    assign f7_alt = (instr[31:25] == 7'h20);

    always_comb begin
        dec        = '0;
        dec.pc     = pc;
        dec.fu_t   = FU_S_T;
        dec.fu_s   = FU_NONE;
        scalar     = 1'b0;
        bad        = 1'b0;
        case (instr[6:0])
            OP_RTYPE: begin
                scalar = 1'b1;
                dec.alu_op = alu_from_f3(f3, f7_alt);
                dec.s_reg_write = 1'b1;
                dec.fu_s = FU_S_ALU;
            end
            OP_ITYPE: begin
                // Only the shift-right form has an alternate encoding with an immediate operand
                scalar = 1'b1;
                dec.alu_op = alu_from_f3(f3, f7_alt && (f3 == 3'd5));
                dec.s_reg_write = 1'b1;
                dec.fu_s = FU_S_ALU;
                dec.i_flag = 1'b1;
                dec.imm = sext(WORD_W'(instr[31:20]), 12);
            end
            OP_LW: begin
                bad = (f3 != F3_WORD);
                scalar = 1'b1;
                dec.s_mem_type = LOAD;
                dec.fu_s = FU_S_LD_ST;
                dec.s_reg_write = 1'b1;
                dec.i_flag = 1'b1;
                dec.imm = sext(WORD_W'(instr[31:20]), 12);
            end
            OP_SW: begin
                bad = (f3 != F3_WORD);
                scalar = 1'b1;
                dec.s_mem_type = STORE;
                dec.fu_s = FU_S_LD_ST;
                dec.i_flag = 1'b1;
                dec.imm = sext(WORD_W'({instr[31:25], instr[11:7]}), 12);
            end
            OP_BTYPE: begin
                scalar = 1'b1;
                dec.fu_s = FU_S_BRANCH;
                dec.imm = sext(WORD_W'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), 13);
                case (f3)
                    3'd0: dec.branch_op = BT_BEQ;
                    3'd1: dec.branch_op = BT_BNE;
                    3'd4: dec.branch_op = BT_BLT;
                    3'd5: dec.branch_op = BT_BGE;
                    3'd6: dec.branch_op = BT_BLTU;
                    3'd7: dec.branch_op = BT_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                scalar = 1'b1;
                dec.imm = sext(WORD_W'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), 21);
                dec.jal = 1'b1;
                dec.s_reg_write = 1'b1;
                dec.alu_op = ALU_ADD;
                dec.i_flag = 1'b1;
                dec.fu_s = FU_S_ALU;
            end
            OP_JALR: begin
                scalar = 1'b1;
                dec.imm = sext(WORD_W'(instr[31:20]), 12);
                dec.jalr = 1'b1;
                dec.s_reg_write = 1'b1;
                dec.alu_op = ALU_ADD;
                dec.i_flag = 1'b1;
                dec.fu_s = FU_S_ALU;
            end
            OP_LD_M, OP_ST_M: begin
                dec.imm = sext(WORD_W'(instr[17:7]), 11);
                dec.stride = instr[22:18];
                dec.mrd = instr[31:28];
                dec.fu_m = FU_M_LD_ST;
                dec.fu_t = FU_M_T;
                dec.m_mem_type = (instr[6:0] == OP_LD_M) ? M_LOAD : M_STORE;
                dec.m_reg_write = (instr[6:0] == OP_LD_M);
            end
            OP_GEMM: begin
                dec.mrd  = instr[GEMM_MRD_LSB  +: MREG_W];
                dec.mrs1 = instr[GEMM_MRS1_LSB +: MREG_W];
                dec.mrs2 = instr[GEMM_MRS2_LSB +: MREG_W];
                dec.mrs3 = instr[GEMM_MRS3_LSB +: MREG_W];
                dec.fu_m = FU_M_GEMM;
                dec.m_reg_write = 1'b1;
                dec.fu_t = FU_G_T;
            end
            OP_HALT: dec.halt = 1'b1;
            default: bad = 1'b1;
        endcase
        if (scalar) begin
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.rs2 = instr[24:20];
        end
        // Illegal words still travel to dispatch, but stripped of every side effect
        if (bad) begin
            dec         = '0;
            dec.pc      = pc;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: FIFO of fetched instructions with flush, halt fencing and head decode.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [WORD_W-1:0]          fetch_instr,
    input  logic [WORD_W-1:0]          fetch_pc,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output decode_t                    dec_out,
    input  logic                       flush,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WORD_W-1:0] q_instr_p0 [DEPTH];
    logic [WORD_W-1:0] q_pc_p0    [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  cnt;
    logic              halt_in_q;
    logic              full;
    logic              push;
    logic              pop;
    decode_t           head_dec;

    assign full        = (cnt == CNT_W'(DEPTH));
    assign fetch_ready = !full && !halt_in_q && !halted;
    assign dec_valid   = (cnt != '0);
    assign push        = fetch_valid && fetch_ready;
    assign pop         = dec_valid && dec_ready;
    assign count       = cnt;

    // Stage p0: queued raw words, decoded straight off the head slot
    instr_decoder u_dec (
        .instr (q_instr_p0[rptr]),
        .pc    (q_pc_p0[rptr]),
        .dec   (head_dec)
    );

    assign dec_out = dec_valid ? head_dec : '0;

    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            q_instr_p0[wptr] <= fetch_instr;
            q_pc_p0[wptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            halt_in_q <= 1'b0;
            halted    <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            halt_in_q <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
                if (fetch_instr[6:0] == OP_HALT)
                    halt_in_q <= 1'b1;
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
                if (head_dec.halt)
                    halted <= 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: handshake, FIFO order/wrap, flush, halt fence and decode fields.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [WORD_W-1:0] fetch_instr;
    logic [WORD_W-1:0] fetch_pc;
    logic              dec_valid;
    logic              dec_ready;
    decode_t           d;
    logic              flush;
    logic              halted;
    logic [2:0]        count;

    int checks   = 0;
    int failures = 0;

    decode_queue #(.DEPTH(4)) dut (
        .CLK         (clk),
        .RST         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_out     (d),
        .flush       (flush),
        .halted      (halted),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_instr = instr;
        fetch_pc    = pc;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic pop_one();
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
    endtask

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | 32'h0000_0093;
    endfunction

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
        dec_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_dec_valid", 64'(dec_valid), 64'(0));
        check("rst_fetch_ready", 64'(fetch_ready), 64'(1));
        check("rst_count", 64'(count), 64'(0));
        check("rst_dec_out_zero", 64'(d == '0), 64'(1));
        check("rst_halted", 64'(halted), 64'(0));

        // addi x1,x0,5 with dispatch ready
        dec_ready = 1'b1;
        push(32'h0050_0093, 32'h100);
        check("addi_valid", 64'(dec_valid), 64'(1));
        check("addi_alu", 64'(d.alu_op), 64'(ALU_ADD));
        check("addi_imm", 64'(d.imm), 64'(5));
        check("addi_rd", 64'(d.rd), 64'(1));
        check("addi_iflag", 64'(d.i_flag), 64'(1));
        check("addi_swr", 64'(d.s_reg_write), 64'(1));
        check("addi_pc", 64'(d.pc), 64'(32'h100));
        check("addi_fus", 64'(d.fu_s), 64'(FU_S_ALU));
        tick();
        check("addi_drained", 64'(count), 64'(0));
        dec_ready = 1'b0;

        // beq x0,x0,-4
        push(32'hFE00_0EE3, 32'h104);
        check("beq_op", 64'(d.branch_op), 64'(BT_BEQ));
        check("beq_imm", 64'(d.imm), 64'(32'hFFFF_FFFC));
        check("beq_fus", 64'(d.fu_s), 64'(FU_S_BRANCH));
        check("beq_nowr", 64'({d.s_reg_write, d.m_reg_write}), 64'(0));
        pop_one();

        // lw x2,8(x1)
        push(32'h0080_A103, 32'h108);
        check("lw_mem", 64'(d.s_mem_type), 64'(LOAD));
        check("lw_fus", 64'(d.fu_s), 64'(FU_S_LD_ST));
        check("lw_imm", 64'(d.imm), 64'(8));
        check("lw_regs", 64'({d.rd, d.rs1, d.s_reg_write}), 64'({5'd2, 5'd1, 1'b1}));
        pop_one();

        // sw x2,12(x1)
        push(32'h0020_A623, 32'h10C);
        check("sw_mem", 64'(d.s_mem_type), 64'(STORE));
        check("sw_imm", 64'(d.imm), 64'(12));
        check("sw_rs2_nowr", 64'({d.rs2, d.s_reg_write}), 64'({5'd2, 1'b0}));
        pop_one();

        // matrix load: mrd=1, stride=3, imm=-1
        push(32'h100F_FF8B, 32'h110);
        check("ldm_imm", 64'(d.imm), 64'(32'hFFFF_FFFF));
        check("ldm_stride_mrd", 64'({d.stride, d.mrd}), 64'({5'd3, 4'd1}));
        check("ldm_kind", 64'({d.fu_m, d.fu_t, d.m_mem_type, d.m_reg_write}),
              64'({FU_M_LD_ST, FU_M_T, M_LOAD, 1'b1}));
        pop_one();

        // sub x3,x1,x2
        push(32'h4020_81B3, 32'h114);
        check("sub_alu", 64'(d.alu_op), 64'(ALU_SUB));
        check("sub_rd_iflag", 64'({d.rd, d.i_flag}), 64'({5'd3, 1'b0}));
        pop_one();

        // Fill to full across the pointer wrap, then mixed push/pop
        for (int k = 0; k < 4; k++) begin
            fetch_valid = 1'b1; fetch_instr = addi(10 + k); fetch_pc = 32'(k);
            tick();
        end
        fetch_valid = 1'b0;
        check("full_count", 64'(count), 64'(4));
        check("full_ready", 64'(fetch_ready), 64'(0));
        check("full_head", 64'(d.imm), 64'(10));
        pop_one();
        check("pop_count", 64'(count), 64'(3));
        check("pop_ready", 64'(fetch_ready), 64'(1));
        fetch_valid = 1'b1; fetch_instr = addi(14); dec_ready = 1'b1;
        tick();
        check("pushpop_count", 64'(count), 64'(3));
        check("pushpop_head", 64'(d.imm), 64'(12));
        dec_ready = 1'b0; fetch_instr = addi(15);
        tick();
        fetch_valid = 1'b0;
        check("refill_count", 64'(count), 64'(4));
        dec_ready = 1'b1;
        for (int k = 12; k < 16; k++) begin
            check($sformatf("order_%0d", k), 64'(d.imm), 64'(k));
            tick();
        end
        dec_ready = 1'b0;
        check("drain_empty", 64'(dec_valid), 64'(0));

        // Flush beats a simultaneous push
        for (int k = 20; k < 23; k++) push(addi(k), 32'h200);
        check("pre_flush_count", 64'(count), 64'(3));
        flush = 1'b1; fetch_valid = 1'b1; fetch_instr = addi(23);
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        check("flush_count", 64'(count), 64'(0));
        check("flush_valid", 64'(dec_valid), 64'(0));
        push(addi(24), 32'h210);
        check("post_flush_head", 64'(d.imm), 64'(24));
        pop_one();

        // GEMM source fields
        push(32'h2345_005B, 32'h300);
        check("gemm_regs", 64'({d.mrd, d.mrs1, d.mrs2, d.mrs3}), 64'(16'h2345));
        check("gemm_kind", 64'({d.fu_t, d.fu_m, d.m_reg_write, d.s_reg_write}),
              64'({FU_G_T, FU_M_GEMM, 1'b1, 1'b0}));
        pop_one();

        // Illegal: unknown opcode and undefined branch funct3
        push(32'h0000_007F, 32'h304);
        check("ill_op", 64'({d.illegal, d.fu_s, d.s_reg_write, d.m_reg_write}),
              64'({1'b1, FU_NONE, 1'b0, 1'b0}));
        check("ill_pc", 64'(d.pc), 64'(32'h304));
        pop_one();
        push(32'h0000_2063, 32'h308);
        check("ill_branch", 64'({d.illegal, d.fu_s}), 64'({1'b1, FU_NONE}));
        pop_one();

        // Flush clears a queued-but-unissued HALT fence
        push(32'h0000_007B, 32'h400);
        check("fence_ready", 64'(fetch_ready), 64'(0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fence_cleared", 64'({fetch_ready, halted, count}), 64'({1'b1, 1'b0, 3'd0}));

        // Issued HALT is sticky through flush
        fetch_valid = 1'b1; fetch_instr = 32'h0000_007B; fetch_pc = 32'h500;
        tick();
        fetch_instr = addi(30);
        check("halt_ready", 64'(fetch_ready), 64'(0));
        check("halt_head", 64'(d.halt), 64'(1));
        tick();
        fetch_valid = 1'b0;
        check("halt_blocked", 64'(count), 64'(1));
        pop_one();
        check("halted_set", 64'({halted, count, fetch_ready}), 64'({1'b1, 3'd0, 1'b0}));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("halted_sticky", 64'(halted), 64'(1));

        // Reset clears halted; reset mid-stream empties the queue
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_unhalt", 64'({halted, fetch_ready}), 64'({1'b0, 1'b1}));
        push(addi(40), 32'h600);
        push(addi(41), 32'h604);
        check("midrst_pre", 64'(count), 64'(2));
        rst = 1'b1; fetch_valid = 1'b1; fetch_instr = addi(42);
        tick();
        rst = 1'b0; fetch_valid = 1'b0;
        check("midrst_count", 64'({count, dec_valid, halted}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
